i2c_init_ctrl: RTL
==================

Name: i2c_init_ctrl

Overview:
- Power-up and bring-up sequencer that sits directly upstream of the register-table I2C configurator.
- Drives the camera sensor power-down and reset pins and applies the required delays.
- Holds the configurator in reset, then releases it and supervises its done/error outputs.
- Retries the whole sequence on I2C error or timeout; reports final init status to the video pipeline.

Parameters:
PWDN_CYCLES, 32'd1000, cycles with sensor powered down and held in reset (≥1)
RST_CYCLES, 32'd1000, cycles powered up with sensor still in reset (≥1)
SETTLE_CYCLES, 32'd5000, cycles after sensor reset release before configuration starts (≥1)
CFG_RST_CYCLES, 8'd4, cycles cfg_rst is pulsed high before configurator runs (≥1)
TIMEOUT_CYCLES, 32'd5000000, max cycles allowed in S_CFG_RUN before declaring timeout (≥1)
MAX_RETRY, 4'd3, retries permitted after the first failed attempt (0 = no retry)

Ports:
clk  input  1  system clock, same domain as configurator
rst_n  input  1  asynchronous active-low reset
restart  input  1  single-cycle pulse; honoured only in S_DONE/S_FAIL
cfg_done  input  1  configurator done (level, stays high once reached)
cfg_error  input  1  configurator sticky error flag
cfg_rst  output  1  active-high async reset to configurator
cam_pwdn  output  1  sensor power-down, 1 = powered down
cam_rst_n  output  1  sensor reset, active low
busy  output  1  high in every state except S_DONE/S_FAIL
init_done  output  1  config completed without error (level)
init_fail  output  1  retries exhausted (level)
retry_count  output  4  failed attempts so far, saturates at 15

Behaviour:
- All outputs are registered. Reset values: cam_pwdn=1, cam_rst_n=0, cfg_rst=1, busy=1, init_done=0, init_fail=0, retry_count=0, state=S_PWDN with counter loaded.
- Single down-counter, 32 bits, loaded on state entry. A timed state with parameter N occupies exactly N clk cycles and then advances.
- Asserting rst_n low at any point, including mid-configuration, returns to reset values immediately. cfg_rst=1 at reset aborts any I2C transfer in progress.
- S_PWDN: cam_pwdn=1, cam_rst_n=0, cfg_rst=1, for PWDN_CYCLES, then go to S_RST.
- S_RST: cam_pwdn=0, cam_rst_n=0, cfg_rst=1, for RST_CYCLES, then go to S_SETTLE.
- S_SETTLE: cam_rst_n=1, cfg_rst=1, for SETTLE_CYCLES, then go to S_CFG_RST.
- S_CFG_RST: cfg_rst=1 for CFG_RST_CYCLES, then go to S_CFG_RUN.
- S_CFG_RUN: cfg_rst=0. cfg_done and cfg_error are ignored in the first cycle of the state, because the configurator is leaving its own reset. From the second cycle:
  - cfg_done=1 and cfg_error=0: go to S_DONE.
  - cfg_done=1 and cfg_error=1: failure.
  - cfg_error=1 alone does not end the state early; the table is allowed to finish.
  - Counter expiry after TIMEOUT_CYCLES with no cfg_done: failure. If cfg_done rises on the same cycle the counter expires, cfg_done wins.
- Failure handling: retry_count increments (saturating). If the pre-increment retry_count < MAX_RETRY, go to S_PWDN for a full power cycle. Otherwise go to S_FAIL.
- S_DONE: init_done=1, busy=0, cfg_rst=0 (configurator left idle in its done state), sensor pins held active.
- S_FAIL: init_fail=1, busy=0, cfg_rst=1, cam_pwdn=1, cam_rst_n=0.
- restart in S_DONE or S_FAIL: clears init_done, init_fail and retry_count, then goes to S_PWDN on the next edge. restart is ignored in every other state.
- init_done and init_fail are never high together.
- Output changes appear on the clock edge that enters the state.

Test Plan:
1. Params PWDN=4, RST=3, SETTLE=5, CFG_RST=2, TIMEOUT=50, MAX_RETRY=2. Release rst_n, configurator model raises cfg_done 10 cycles into S_CFG_RUN with error=0 -> cam_pwdn falls after exactly 4 cycles, cam_rst_n rises 3 cycles later, cfg_rst falls 7 cycles after that; init_done=1, busy=0, retry_count=0.
2. Model returns done with cfg_error=1 on every attempt -> three full power cycles (cam_pwdn re-asserts twice), then init_fail=1, retry_count=3, cfg_rst=1, cam_pwdn=1.
3. Model never raises cfg_done -> S_CFG_RUN lasts exactly 50 cycles; fails twice, passes on the third attempt -> init_done=1, retry_count=2.
4. cfg_done rises on the exact cycle the timeout counter expires -> S_DONE, init_done=1, retry_count unchanged.
5. rst_n pulsed low midway through S_CFG_RUN -> cfg_rst=1, cam_pwdn=1, cam_rst_n=0 asynchronously; the sequence restarts from S_PWDN with retry_count=0.
6. restart pulsed during S_SETTLE -> ignored, timing unchanged. restart pulsed in S_FAIL -> init_fail clears, retry_count=0, cam_pwdn=1 held for 4 cycles, full sequence repeats.

Source files
------------

// File: rtl/i2c_init_ctrl.sv
// Camera sensor power-up sequencer: sequences sensor power-down and reset pins,
// holds the I2C register configurator in reset, then supervises its done/error
// flags, retrying the full power cycle on error or timeout.
module i2c_init_ctrl #(
    parameter logic [31:0] PWDN_CYCLES    = 32'd1000,
    parameter logic [31:0] RST_CYCLES     = 32'd1000,
    parameter logic [31:0] SETTLE_CYCLES  = 32'd5000,
    parameter logic [7:0]  CFG_RST_CYCLES = 8'd4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd5000000,
    parameter logic [3:0]  MAX_RETRY      = 4'd3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       restart,
    input  logic       cfg_done,
    input  logic       cfg_error,
    output logic       cfg_rst,
    output logic       cam_pwdn,
    output logic       cam_rst_n,
    output logic       busy,
    output logic       init_done,
    output logic       init_fail,
    output logic [3:0] retry_count
);

    typedef enum logic [2:0] {
        S_PWDN,
        S_RST,
        S_SETTLE,
        S_CFG_RST,
        S_CFG_RUN,
        S_DONE,
        S_FAIL
    } state_e;

    localparam logic [3:0] RETRY_SAT = 4'd15;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        first_q, first_d;
    logic [3:0]  retry_q, retry_d;
    logic        attempt_failed;

    logic cfg_rst_q, cam_pwdn_q, cam_rst_n_q, busy_q, init_done_q, init_fail_q;
    logic cfg_rst_d, cam_pwdn_d, cam_rst_n_d, busy_d, init_done_d, init_fail_d;

    // Counter preload so that a timed state lasts exactly N cycles (N-1 down to 0).
    function automatic logic [31:0] load_value(input state_e s);
        case (s)
            S_PWDN:    load_value = PWDN_CYCLES - 32'd1;
            S_RST:     load_value = RST_CYCLES - 32'd1;
            S_SETTLE:  load_value = SETTLE_CYCLES - 32'd1;
            S_CFG_RST: load_value = {24'd0, CFG_RST_CYCLES} - 32'd1;
            S_CFG_RUN: load_value = TIMEOUT_CYCLES - 32'd1;
            default:   load_value = 32'd0;
        endcase
    endfunction

    // Next-state, counter and retry bookkeeping.
    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        state_d        = state_q;
        cnt_d          = cnt_q;
        first_d        = 1'b0;
        retry_d        = retry_q;
        attempt_failed = 1'b0;

        case (state_q)
            S_PWDN:    if (cnt_q == 32'd0) state_d = S_RST;     else cnt_d = cnt_q - 32'd1;
            S_RST:     if (cnt_q == 32'd0) state_d = S_SETTLE;  else cnt_d = cnt_q - 32'd1;
            S_SETTLE:  if (cnt_q == 32'd0) state_d = S_CFG_RST; else cnt_d = cnt_q - 32'd1;
            S_CFG_RST: if (cnt_q == 32'd0) state_d = S_CFG_RUN; else cnt_d = cnt_q - 32'd1;
            S_CFG_RUN: begin
                // Configurator flags are meaningless while it leaves its own reset.
                if (!first_q && cfg_done) begin
                    if (cfg_error) attempt_failed = 1'b1;
                    else           state_d = S_DONE;
                end else if (cnt_q == 32'd0) begin
                    attempt_failed = 1'b1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_DONE, S_FAIL: begin
                if (restart) begin
                    state_d = S_PWDN;
                    retry_d = 4'd0;
                end
            end
            default: state_d = S_PWDN;
        endcase

        if (attempt_failed) begin
            retry_d = (retry_q == RETRY_SAT) ? RETRY_SAT : retry_q + 4'd1;
            state_d = (retry_q < MAX_RETRY) ? S_PWDN : S_FAIL;
        end

        if (state_d != state_q) begin
            cnt_d   = load_value(state_d);
            first_d = (state_d == S_CFG_RUN);
        end
    end

    // Output decode from the next state so pins change on the entering edge.
    always_comb begin
        cfg_rst_d   = 1'b1;
        cam_pwdn_d  = 1'b0;
        cam_rst_n_d = 1'b1;
        busy_d      = 1'b1;
        init_done_d = 1'b0;
        init_fail_d = 1'b0;
        case (state_d)
            S_PWDN:   begin cam_pwdn_d = 1'b1; cam_rst_n_d = 1'b0; end
            S_RST:    cam_rst_n_d = 1'b0;
            S_CFG_RUN: cfg_rst_d = 1'b0;
            S_DONE:   begin cfg_rst_d = 1'b0; busy_d = 1'b0; init_done_d = 1'b1; end
            S_FAIL:   begin
                cam_pwdn_d  = 1'b1;
                cam_rst_n_d = 1'b0;
                busy_d      = 1'b0;
                init_fail_d = 1'b1;
            end
            default:  ;
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_PWDN;
            cnt_q       <= PWDN_CYCLES - 32'd1;
            first_q     <= 1'b0;
            retry_q     <= 4'd0;
            cfg_rst_q   <= 1'b1;
            cam_pwdn_q  <= 1'b1;
            cam_rst_n_q <= 1'b0;
            busy_q      <= 1'b1;
            init_done_q <= 1'b0;
            init_fail_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all registers updating on the same edge.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            retry_q     <= retry_d;
            cfg_rst_q   <= cfg_rst_d;
            cam_pwdn_q  <= cam_pwdn_d;
            cam_rst_n_q <= cam_rst_n_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
            init_fail_q <= init_fail_d;
        end
    end

    assign cfg_rst     = cfg_rst_q;
    assign cam_pwdn    = cam_pwdn_q;
    assign cam_rst_n   = cam_rst_n_q;
    assign busy        = busy_q;
    assign init_done   = init_done_q;
    assign init_fail   = init_fail_q;
    assign retry_count = retry_q;

endmodule
